util_axis_uart_rx: RTL and testbench
====================================

# util_axis_uart_rx

Standalone UART receiver that deserialises an asynchronous serial line into AXI-Stream beats, one character per beat. It decodes the same framing that util_axis_uart transmits (start, LSB-first data, optional parity, stop bits). It sits between a board-level rx pin and any AXIS consumer, and replaces ad-hoc serial stimulus in loopback benches.

## Interface
- baud_clock_speed, 50000000, aclk frequency in Hz
- baud_rate, 2000000, line rate in bit/s; CPB = baud_clock_speed/baud_rate (integer divide), must be >= 4
- parity_ena, 0, 1 = parity bit present after data
- parity_type, 0, 0 = even, 1 = odd
- stop_bits, 1, number of stop bits, 1 or 2
- data_bits, 8, character width, 5 to 8
- aclk  input  1  sole clock
- arstn  input  1  asynchronous active-low reset
- rx  input  1  serial line, idle high, asynchronous to aclk
- m_axis_tdata  output  data_bits  received character
- m_axis_tvalid  output  1  character valid
- m_axis_tready  input  1  consumer ready
- m_axis_tuser  output  2  {frame_err, parity_err} for the held character
- overrun  output  1  one-cycle pulse, character dropped

## Operation
- rx passes through a 2-flop synchroniser (rx_s), reset value 1; all decisions use rx_s.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH. Reset state is IDLE.
- IDLE: on rx_s = 0, load bit counter with CPB/2 - 1 and go to START.
- START: at counter expiry (half bit), rx_s = 0 -> reload CPB-1, go to DATA; rx_s = 1 -> glitch, return to IDLE, no output.
- DATA: sample every CPB cycles and shift into shift register LSB first; after data_bits samples go to PARITY if parity_ena, else STOP.
- PARITY: sample one bit; parity_err = (XOR of data bits XOR sampled bit) != parity_type.
- STOP: sample stop_bits bits; any 0 sets frame_err. After the last stop sample, deliver the character. Go to IDLE if no frame_err, else to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s = 1, then go to IDLE. This prevents a break from re-triggering.
- Delivery: if the output register is empty, or is being consumed in the same cycle (tvalid & tready), load tdata/tuser and set tvalid. Otherwise keep the held beat unchanged, drop the new character, and pulse overrun.
- Handshake: tvalid stays high, and tdata/tuser stay stable, until tvalid & tready; then tvalid clears on the next edge unless a simultaneous delivery reloads it.
- Frame and parity errors do not suppress delivery; they are reported in tuser with the character.

## Timing
- Reset values: m_axis_tvalid 0, m_axis_tdata 0, m_axis_tuser 0, overrun 0, internal counters 0.
- Reset asserted mid-frame: the FSM returns to IDLE immediately, and any held beat is discarded.
- Synchroniser latency is 2 cycles. Start is verified CPB/2 cycles after the first low rx_s. Each later sample is exactly CPB cycles after the previous one.
- m_axis_tvalid rises 1 cycle after the final stop-bit sample edge.
- End-to-end latency, with rx falling aligned to aclk: 2 + CPB/2 + CPB*(data_bits + parity_ena + stop_bits) + 1 cycles.
- The receiver is back in IDLE in the same cycle as delivery. A start bit arriving half a stop bit later is accepted, which tolerates back-to-back frames with clock error up to about 1/(2*frame length).
- Counter width is clog2(CPB). All division is done at elaboration; there is no runtime arithmetic beyond the decrement.

## Configuration
- UTIL_AXIS_UART_RX_GLITCH_FILTER_EN defined:
  - every start, data, parity and stop sample is a 2-of-3 majority of rx_s at mid-1, mid and mid+1;
  - requires CPB >= 6;
  - delivery is delayed by 1 extra cycle.
- Not defined: a single sample of rx_s at mid-bit.

## Test plan
- CPB = 25, 8N1, frame for 0x41 -> one beat, tdata 0x41, tuser 00, tvalid at the computed latency (2+12+225+1 = 240 cycles).
- parity_ena=1, parity_type=0, 0x41 sent with parity bit 1 -> tdata 0x41, tuser 01. With parity bit 0 -> tuser 00.
- 0x55 with stop bit forced 0, rx then held low for 3 bit times -> tdata 0x55, tuser 10. No second beat until rx returns high and a new start arrives.
- rx low for 5 cycles during idle -> no tvalid, FSM back in IDLE. A following valid frame for 0xA5 -> tdata 0xA5.
- m_axis_tready held 0, frames 0x41 then 0x42 -> tdata stays 0x41, one overrun pulse at 0x42 delivery. Raise tready -> 0x41 consumed, no 0x42 beat.
- arstn pulsed low during data bit 4 of 0x41 -> outputs 0 within the reset. Next full frame 0x42 -> tdata 0x42, tuser 00.

Source files
------------

// File: rtl/util_axis_uart_rx.sv
// UART receiver: rx pin to AXI-Stream, one character per beat.
// Optional `UTIL_AXIS_UART_RX_GLITCH_FILTER_EN: 2-of-3 majority vote per sample.
module util_axis_uart_rx #(
    parameter int baud_clock_speed = 50000000,
    parameter int baud_rate        = 2000000,
    parameter int parity_ena       = 0,
    parameter int parity_type      = 0,
    parameter int stop_bits        = 1,
    parameter int data_bits        = 8
) (
    input  logic                 aclk,
    input  logic                 arstn,
    input  logic                 rx,
    output logic [data_bits-1:0] m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [1:0]           m_axis_tuser,
    output logic                 overrun
);

    localparam int CPB = baud_clock_speed / baud_rate;
    localparam int CW  = $clog2(CPB);
    localparam logic [CW-1:0] C_FULL = CW'(CPB - 1);
    localparam logic [2:0] C_DLAST = 3'(data_bits - 1);
    localparam logic [2:0] C_SLAST = 3'(stop_bits - 1);
    localparam logic       C_PTYPE = 1'(parity_type);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [1:0]             r_sync;
    logic [CW-1:0]          r_cnt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [2:0]             r_bitcnt;
    logic [2:0]             w_bitcnt_nxt;
    logic [data_bits-1:0]   r_shift;
    logic [data_bits-1:0]   w_shift_nxt;
    logic                   r_perr;
    logic                   w_perr_nxt;
    logic                   r_ferr;
    logic                   w_ferr_nxt;
    logic                   w_ferr_now;
    logic                   w_deliver;
    logic                   w_rx_s;
    logic                   w_bit;
    logic                   w_tick;
    logic                   w_fire;
    logic [data_bits-1:0]   r_tdata;
    logic [1:0]             r_tuser;
    logic                   r_tvalid;
    logic                   r_overrun;

    assign w_rx_s = r_sync[1];

`ifdef UTIL_AXIS_UART_RX_GLITCH_FILTER_EN
    // Every sample point moves one cycle later so the vote spans mid-1..mid+1.
    localparam logic [CW-1:0] C_HALF = CW'(CPB / 2);
    logic [1:0] r_hist;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_hist <= 2'b11;
        end else begin
            r_hist <= {r_hist[0], w_rx_s};
        end
    end

    assign w_bit = (r_hist[1] & r_hist[0]) |
                   (r_hist[1] & w_rx_s) |
                   (r_hist[0] & w_rx_s);
`else
    localparam logic [CW-1:0] C_HALF = CW'(CPB / 2 - 1);
    assign w_bit = w_rx_s;
`endif

    assign w_tick     = (r_cnt == '0);
    assign w_ferr_now = r_ferr | ~w_bit;
    assign w_fire     = r_tvalid & m_axis_tready;

    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_sync   <= 2'b11;
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
        end else begin
            r_sync   <= {r_sync[0], rx};
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shift  <= w_shift_nxt;
            r_perr   <= w_perr_nxt;
            r_ferr   <= w_ferr_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = w_tick ? '0 : r_cnt - CW'(1);
        w_bitcnt_nxt = r_bitcnt;
        w_shift_nxt  = r_shift;
        w_perr_nxt   = r_perr;
        w_ferr_nxt   = r_ferr;
        w_deliver    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!w_rx_s) begin
                    w_cnt_nxt    = C_HALF;
                    w_bitcnt_nxt = '0;
                    w_perr_nxt   = 1'b0;
                    w_ferr_nxt   = 1'b0;
                    w_state_nxt  = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (!w_bit) begin
                        w_cnt_nxt   = C_FULL;
                        w_state_nxt = S_DATA;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    w_cnt_nxt   = C_FULL;
                    w_shift_nxt = {w_bit, r_shift[data_bits-1:1]};
                    if (r_bitcnt == C_DLAST) begin
                        w_bitcnt_nxt = '0;
                        w_state_nxt  = (parity_ena != 0) ? S_PARITY : S_STOP;
                    end else begin
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
            end
            S_PARITY: begin
                if (w_tick) begin
                    w_cnt_nxt   = C_FULL;
                    w_perr_nxt  = ((^r_shift) ^ w_bit) != C_PTYPE;
                    w_state_nxt = S_STOP;
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    w_ferr_nxt = w_ferr_now;
                    if (r_bitcnt == C_SLAST) begin
                        w_deliver   = 1'b1;
                        w_state_nxt = w_ferr_now ? S_WAIT_HIGH : S_IDLE;
                    end else begin
                        w_cnt_nxt    = C_FULL;
                        w_bitcnt_nxt = r_bitcnt + 3'd1;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (w_rx_s) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // A held beat is never overwritten; a late character is dropped instead.
    always_ff @(posedge aclk or negedge arstn) begin
        if (!arstn) begin
            r_tdata   <= '0;
            r_tuser   <= '0;
            r_tvalid  <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (w_deliver && (!r_tvalid || w_fire)) begin
                r_tdata  <= r_shift;
                r_tuser  <= {w_ferr_now, r_perr};
                r_tvalid <= 1'b1;
            end else begin
                if (w_deliver) begin
                    r_overrun <= 1'b1;
                end
                if (w_fire) begin
                    r_tvalid <= 1'b0;
                end
            end
        end
    end

    assign m_axis_tdata  = r_tdata;
    assign m_axis_tuser  = r_tuser;
    assign m_axis_tvalid = r_tvalid;
    assign overrun       = r_overrun;

endmodule

// File: tb/tb_util_axis_uart_rx.sv
// Bench for util_axis_uart_rx: an 8N1 instance and an 8E2 instance
// against a frame-level timing/data model plus pinned literal checks.
module tb_util_axis_uart_rx;

    localparam int CPB = 50000000 / 2000000;
`ifdef UTIL_AXIS_UART_RX_GLITCH_FILTER_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    typedef struct {
        int unsigned t;
        int          k;
        logic [7:0]  d;
        logic [1:0]  u;
    } exp_t;

    logic       clk;
    logic       arstn;
    logic [1:0] rx_l;
    logic [1:0] tready;
    logic [1:0] tv;
    logic [1:0] ov;
    logic [7:0] td [2];
    logic [1:0] tu [2];

    int          vectors;
    int          miscompares;
    int unsigned cyc;
    int unsigned last_t0;
    int          tr_mode [2];
    exp_t        q[$];
    exp_t        e;
    logic [1:0]  m_v;
    logic [1:0]  m_ov;
    logic [7:0]  m_d [2];
    logic [1:0]  m_u [2];
    logic [1:0]  prev_tv;
    int unsigned rise_cyc [2];
    logic [7:0]  rise_d [2];
    logic [1:0]  rise_u [2];
    int          rise_n [2];
    int          ov_cnt [2];

    util_axis_uart_rx #(
        .baud_clock_speed(50000000), .baud_rate(2000000),
        .parity_ena(0), .parity_type(0), .stop_bits(1), .data_bits(8)
    ) u_dut0 (
        .aclk(clk), .arstn(arstn), .rx(rx_l[0]),
        .m_axis_tdata(td[0]), .m_axis_tvalid(tv[0]),
        .m_axis_tready(tready[0]), .m_axis_tuser(tu[0]),
        .overrun(ov[0])
    );

    util_axis_uart_rx #(
        .baud_clock_speed(50000000), .baud_rate(2000000),
        .parity_ena(1), .parity_type(0), .stop_bits(2), .data_bits(8)
    ) u_dut1 (
        .aclk(clk), .arstn(arstn), .rx(rx_l[1]),
        .m_axis_tdata(td[1]), .m_axis_tvalid(tv[1]),
        .m_axis_tready(tready[1]), .m_axis_tuser(tu[1]),
        .overrun(ov[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h required %0h", nm, act, req);
        end
    endtask

    // Delivery edge measured from the aclk edge after which rx falls.
    function automatic int unsigned lat(input int k);
        int nbits;
        nbits = (k == 0) ? 9 : 11;
        return 2 + CPB / 2 + CPB * nbits + 1 + XL;
    endfunction

    always @(negedge clk) begin
        if (!arstn) begin
            m_v  = '0;
            m_ov = '0;
            m_d[0] = '0; m_d[1] = '0;
            m_u[0] = '0; m_u[1] = '0;
            q.delete();
        end else begin
            m_ov = '0;
            for (int k = 0; k < 2; k++) begin
                if (m_v[k] && tready[k]) m_v[k] = 1'b0;
            end
            if (q.size() > 0 && q[0].t <= cyc) begin
                e = q.pop_front();
                chk("deliver_time", cyc, e.t);
                if (!m_v[e.k]) begin
                    m_v[e.k] = 1'b1;
                    m_d[e.k] = e.d;
                    m_u[e.k] = e.u;
                end else begin
                    m_ov[e.k] = 1'b1;
                end
            end
        end
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("tvalid%0d", k), 32'(tv[k]), 32'(m_v[k]));
            chk($sformatf("overrun%0d", k), 32'(ov[k]), 32'(m_ov[k]));
            if (m_v[k] || !arstn) begin
                chk($sformatf("tdata%0d", k), 32'(td[k]), 32'(m_d[k]));
                chk($sformatf("tuser%0d", k), 32'(tu[k]), 32'(m_u[k]));
            end
            if (tv[k] && !prev_tv[k]) begin
                rise_cyc[k] = cyc;
                rise_d[k]   = td[k];
                rise_u[k]   = tu[k];
                rise_n[k]++;
            end
            prev_tv[k] = tv[k];
            ov_cnt[k] += int'(ov[k]);
            case (tr_mode[k])
                0:       tready[k] = 1'b0;
                1:       tready[k] = 1'b1;
                default: tready[k] = 1'($urandom_range(0, 1));
            endcase
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Entered and left at 1 ns after a rising edge.
    task automatic send(input int k, input logic [7:0] d, input bit flip,
                        input bit bad, input int hold, input int abort_bit,
                        input int gap);
        logic b [12];
        int   n;
        exp_t x;
        n = (k == 0) ? 10 : 12;
        b[0] = 1'b0;
        for (int i = 0; i < 8; i++) b[1+i] = d[i];
        if (k == 1) begin
            b[9]  = (^d) ^ flip;
            b[10] = ~bad;
            b[11] = 1'b1;
        end else begin
            b[9] = ~bad;
        end
        last_t0 = cyc;
        if (abort_bit < 0) begin
            x.t = cyc + lat(k);
            x.k = k;
            x.d = d;
            x.u = {bad, (k == 1) ? flip : 1'b0};
            q.push_back(x);
        end
        for (int i = 0; i < n; i++) begin
            rx_l[k] = b[i];
            if (abort_bit >= 0 && i == abort_bit + 1) begin
                idle(CPB / 2);
                arstn   = 1'b0;
                rx_l[k] = 1'b1;
                idle(3);
                chk("rst_tvalid", 32'(tv[k]), 32'd0);
                chk("rst_tdata", 32'(td[k]), 32'd0);
                chk("rst_tuser", 32'(tu[k]), 32'd0);
                arstn = 1'b1;
                idle(CPB);
                return;
            end
            idle(CPB);
        end
        if (hold > 0) begin
            rx_l[k] = 1'b0;
            idle(hold);
        end
        rx_l[k] = 1'b1;
        if (gap > 0) idle(gap);
    endtask

    initial begin
        int n0;
        int o0;
        int k;
        bit bad;
        vectors     = 0;
        miscompares = 0;
        arstn       = 1'b0;
        rx_l        = 2'b11;
        tready      = 2'b00;
        tr_mode[0]  = 1;
        tr_mode[1]  = 1;
        prev_tv     = '0;
        m_v = '0; m_ov = '0;
        for (int i = 0; i < 2; i++) begin
            rise_n[i] = 0; ov_cnt[i] = 0; rise_cyc[i] = 0;
            rise_d[i] = '0; rise_u[i] = '0;
            m_d[i] = '0; m_u[i] = '0;
        end
        idle(3);
        chk("reset_tvalid", 32'(tv), 32'd0);
        chk("reset_tdata", 32'(td[0]), 32'd0);
        chk("reset_tuser", 32'(tu[0]), 32'd0);
        chk("reset_overrun", 32'(ov), 32'd0);
        arstn = 1'b1;
        idle(5);

        send(0, 8'h41, 0, 0, 0, -1, 20);
        chk("8n1_latency", rise_cyc[0] - last_t0, 32'(240 + XL));
        chk("8n1_data", 32'(rise_d[0]), 32'h41);
        chk("8n1_user", 32'(rise_u[0]), 32'h0);

        send(1, 8'h41, 1, 0, 0, -1, 20);
        chk("par1_latency", rise_cyc[1] - last_t0, 32'(290 + XL));
        chk("par1_data", 32'(rise_d[1]), 32'h41);
        chk("par1_user", 32'(rise_u[1]), 32'h1);
        send(1, 8'h41, 0, 0, 0, -1, 20);
        chk("par0_user", 32'(rise_u[1]), 32'h0);

        n0 = rise_n[0];
        send(0, 8'h55, 0, 1, 3 * CPB, -1, 30);
        chk("break_data", 32'(rise_d[0]), 32'h55);
        chk("break_user", 32'(rise_u[0]), 32'h2);
        chk("break_beats", 32'(rise_n[0] - n0), 32'd1);

        n0 = rise_n[0];
        rx_l[0] = 1'b0;
        idle(5);
        rx_l[0] = 1'b1;
        idle(2 * CPB);
        chk("glitch_beats", 32'(rise_n[0] - n0), 32'd0);
        send(0, 8'hA5, 0, 0, 0, -1, 20);
        chk("glitch_next", 32'(rise_d[0]), 32'hA5);

        tr_mode[0] = 0;
        idle(2);
        n0 = rise_n[0];
        o0 = ov_cnt[0];
        send(0, 8'h41, 0, 0, 0, -1, 5);
        send(0, 8'h42, 0, 0, 0, -1, 10);
        chk("ovr_pulses", 32'(ov_cnt[0] - o0), 32'd1);
        chk("ovr_held", 32'(td[0]), 32'h41);
        tr_mode[0] = 1;
        idle(10);
        chk("ovr_drained", 32'(tv[0]), 32'd0);
        chk("ovr_beats", 32'(rise_n[0] - n0), 32'd1);

        tr_mode[0] = 0;
        idle(2);
        send(0, 8'h33, 0, 0, 0, -1, 10);
        send(0, 8'h41, 0, 0, 0, 4, 0);
        tr_mode[0] = 1;
        idle(2 * CPB);
        send(0, 8'h42, 0, 0, 0, -1, 20);
        chk("rst_next_data", 32'(rise_d[0]), 32'h42);
        chk("rst_next_user", 32'(rise_u[0]), 32'h0);

        tr_mode[0] = 2;
        tr_mode[1] = 2;
        for (int i = 0; i < 60; i++) begin
            k   = int'($urandom_range(0, 1));
            bad = ($urandom_range(0, 5) == 0);
            send(k, 8'($urandom), ($urandom_range(0, 3) == 0), bad, 0, -1,
                 bad ? int'($urandom_range(2, 30))
                     : int'($urandom_range(0, 30)));
        end
        tr_mode[0] = 1;
        tr_mode[1] = 1;
        idle(400);
        chk("drain", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
